// File: rtl/axi_pkg.sv
// Shared AXI read-path types and defaults, common to the read initiator and the read slave.
package axi_pkg;

  localparam int unsigned AxiAddrBits = 32;
  localparam int unsigned AxiDataBits = 32;
  localparam int unsigned AxiLenBits  = 8;
  localparam int unsigned AxiSizeBits = 3;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10,
    BurstRsvd  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAddr = 2'b01,
    StData = 2'b10
  } rd_state_t;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_rd_slice.sv
// Single-entry valid/ready register slice; refills in the same cycle its entry drains.
module axi_rd_slice #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [Width-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [Width-1:0] o_data
);

  logic             r_valid;
  logic [Width-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/axi_master_rd.sv
// AXI read initiator: one command at a time, AR issue, R beats into a registered output stage,
// merged response and last-beat consistency reported on a done pulse.
module axi_master_rd
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_BITS = AxiAddrBits,
  parameter int unsigned DATA_BITS = AxiDataBits,
  parameter int unsigned LEN_BITS  = AxiLenBits,
  parameter int unsigned SIZE_BITS = AxiSizeBits,
  parameter logic [3:0]  AR_CACHE  = 4'b0000
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [LEN_BITS-1:0]  cmd_len,
  input  logic [SIZE_BITS-1:0] cmd_size,
  input  logic [1:0]           cmd_burst,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_BITS-1:0] ar_addr,
  output logic [LEN_BITS-1:0]  ar_len,
  output logic [SIZE_BITS-1:0] ar_size,
  output logic [1:0]           ar_burst,
  output logic [3:0]           ar_cache,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [DATA_BITS-1:0] r_data,
  input  logic                 r_last,
  input  logic [1:0]           r_resp,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_BITS-1:0] rd_data,
  output logic [1:0]           rd_resp,
  output logic                 rd_last,
  output logic                 done,
  output logic [1:0]           done_resp,
  output logic                 done_last_err
);

  localparam int unsigned MaxSize   = $clog2(DATA_BITS / 8);
  localparam int unsigned SliceBits = DATA_BITS + 3;

  rd_state_t            r_state, w_state_d;
  logic [ADDR_BITS-1:0] r_addr, w_addr_d;
  logic [LEN_BITS-1:0]  r_len, w_len_d;
  logic [SIZE_BITS-1:0] r_size, w_size_d;
  logic [1:0]           r_burst, w_burst_d;
  logic [LEN_BITS-1:0]  r_beat_cnt, w_beat_cnt_d;
  logic [1:0]           r_resp_acc, w_resp_acc_d;
  logic                 r_last_err, w_last_err_d;
  logic                 r_done, w_done_d;
  logic [1:0]           r_done_resp, w_done_resp_d;
  logic                 r_done_last_err, w_done_last_err_d;

  logic                 w_cmd_bad;
  logic                 w_slice_rdy;
  logic                 w_beat;
  logic                 w_cnt_zero;
  logic [SliceBits-1:0] w_slice_in;
  logic [SliceBits-1:0] w_slice_out;

  assign w_cmd_bad  = (cmd_burst == BurstRsvd) || (cmd_size > SIZE_BITS'(MaxSize));
  assign w_cnt_zero = (r_beat_cnt == '0);
  assign w_beat     = r_valid && r_ready;
  assign w_slice_in = {r_data, r_resp, w_cnt_zero};

  assign cmd_ready     = (r_state == StIdle);
  assign ar_valid      = (r_state == StAddr);
  assign ar_addr       = r_addr;
  assign ar_len        = r_len;
  assign ar_size       = r_size;
  assign ar_burst      = r_burst;
  assign ar_cache      = AR_CACHE;
  assign r_ready       = (r_state == StData) && w_slice_rdy;
  assign rd_data       = w_slice_out[SliceBits-1:3];
  assign rd_resp       = w_slice_out[2:1];
  assign rd_last       = w_slice_out[0];
  assign done          = r_done;
  assign done_resp     = r_done_resp;
  assign done_last_err = r_done_last_err;

  axi_rd_slice #(
    .Width (SliceBits)
  ) u_slice (
    .i_clk   (aclk),
    .i_rst_n (areset_n),
    .i_valid (w_beat),
    .o_ready (w_slice_rdy),
    .i_data  (w_slice_in),
    .o_valid (rd_valid),
    .i_ready (rd_ready),
    .o_data  (w_slice_out)
  );

  always_comb begin
    w_state_d         = r_state;
    w_addr_d          = r_addr;
    w_len_d           = r_len;
    w_size_d          = r_size;
    w_burst_d         = r_burst;
    w_beat_cnt_d      = r_beat_cnt;
    w_resp_acc_d      = r_resp_acc;
    w_last_err_d      = r_last_err;
    w_done_d          = 1'b0;
    w_done_resp_d     = r_done_resp;
    w_done_last_err_d = r_done_last_err;
    unique case (r_state)
      StIdle: begin
        if (cmd_valid) begin
          if (w_cmd_bad) begin
            // Rejected without touching the bus; report as a slave error.
            w_done_d          = 1'b1;
            w_done_resp_d     = RespSlverr;
            w_done_last_err_d = 1'b0;
          end else begin
            w_addr_d  = cmd_addr;
            w_len_d   = cmd_len;
            w_size_d  = cmd_size;
            w_burst_d = cmd_burst;
            w_state_d = StAddr;
          end
        end
      end
      StAddr: begin
        if (ar_ready) begin
          w_beat_cnt_d = r_len;
          w_state_d    = StData;
        end
      end
      StData: begin
        if (w_beat) begin
          w_resp_acc_d = resp_max(r_resp_acc, r_resp);
          w_last_err_d = r_last_err || (r_last != w_cnt_zero);
          w_beat_cnt_d = r_beat_cnt - 1'b1;
          // The internal count, not r_last, ends the burst.
          if (w_cnt_zero) begin
            w_done_d          = 1'b1;
            w_done_resp_d     = w_resp_acc_d;
            w_done_last_err_d = w_last_err_d;
            w_resp_acc_d      = '0;
            w_last_err_d      = 1'b0;
            w_beat_cnt_d      = '0;
            w_state_d         = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state         <= StIdle;
      r_addr          <= '0;
      r_len           <= '0;
      r_size          <= '0;
      r_burst         <= '0;
      r_beat_cnt      <= '0;
      r_resp_acc      <= '0;
      r_last_err      <= 1'b0;
      r_done          <= 1'b0;
      r_done_resp     <= '0;
      r_done_last_err <= 1'b0;
    end else begin
      r_state         <= w_state_d;
      r_addr          <= w_addr_d;
      r_len           <= w_len_d;
      r_size          <= w_size_d;
      r_burst         <= w_burst_d;
      r_beat_cnt      <= w_beat_cnt_d;
      r_resp_acc      <= w_resp_acc_d;
      r_last_err      <= w_last_err_d;
      r_done          <= w_done_d;
      r_done_resp     <= w_done_resp_d;
      r_done_last_err <= w_done_last_err_d;
    end
  end

endmodule

// File: tb/tb_axi_master_rd.sv
// Directed bench for axi_master_rd: expected beats and done reports are queued when R beats and
// commands are driven, then popped and compared as the local side produces them.
module tb_axi_master_rd;

  logic        aclk;
  logic        areset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [3:0]  ar_cache;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic        r_last;
  logic [1:0]  r_resp;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic        rd_last;
  logic        done;
  logic [1:0]  done_resp;
  logic        done_last_err;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } beat_t;

  beat_t      sb[$];
  logic [2:0] dq[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  logic       rd_toggle = 1'b0;

  axi_master_rd dut (
    .aclk          (aclk),
    .areset_n      (areset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .cmd_size      (cmd_size),
    .cmd_burst     (cmd_burst),
    .ar_valid      (ar_valid),
    .ar_ready      (ar_ready),
    .ar_addr       (ar_addr),
    .ar_len        (ar_len),
    .ar_size       (ar_size),
    .ar_burst      (ar_burst),
    .ar_cache      (ar_cache),
    .r_valid       (r_valid),
    .r_ready       (r_ready),
    .r_data        (r_data),
    .r_last        (r_last),
    .r_resp        (r_resp),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_resp       (rd_resp),
    .rd_last       (rd_last),
    .done          (done),
    .done_resp     (done_resp),
    .done_last_err (done_last_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Local consumer: always ready, or alternating when rd_toggle is set.
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      rd_ready = rd_toggle ? ~rd_ready : 1'b1;
    end
  end

  always @(negedge aclk) begin : monitor
    beat_t      e;
    logic [2:0] d;
    if (areset_n && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rd_data", rd_data, e.d);
        check("rd_resp", rd_resp, e.r);
        check("rd_last", rd_last, e.l);
      end
    end
    if (areset_n && done) begin
      if (dq.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        d = dq.pop_front();
        check("done_resp", done_resp, d[2:1]);
        check("done_last_err", done_last_err, d[0]);
      end
    end
  end

  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input int ar_delay,
                           input logic [31:0] data0, input logic [31:0] resp_pat,
                           input logic [15:0] last_pat, input int abort_after);
    logic [1:0] exp_resp;
    logic       exp_err;
    logic       got;
    exp_resp = 2'b00;
    exp_err  = 1'b0;
    @(posedge aclk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = 3'd2;
    cmd_burst = 2'b01;
    @(negedge aclk);
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
    r_valid   = 1'b1;
    r_data    = 32'hDEAD_BEEF;
    for (int i = 0; i <= ar_delay; i++) begin
      ar_ready = (i == ar_delay);
      @(negedge aclk);
      check("ar_valid", ar_valid, 1);
      check("ar_addr", ar_addr, addr);
      check("ar_len", ar_len, len);
      check("ar_size", ar_size, 3'd2);
      check("ar_burst", ar_burst, 2'b01);
      check("ar_cache", ar_cache, 4'b0000);
      check("r_ready_in_addr", r_ready, 0);
      check("cmd_ready_busy", cmd_ready, 0);
      @(posedge aclk);
      #1;
    end
    ar_ready = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == abort_after) begin
        r_valid = 1'b0;
        return;
      end
      r_valid = 1'b1;
      r_data  = (b == 0) ? data0 : $urandom;
      r_resp  = resp_pat[2*b+:2];
      r_last  = last_pat[b];
      got     = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
        @(negedge aclk);
        check("r_ready_track", r_ready, !rd_valid || rd_ready);
        if (r_ready) begin
          got = 1'b1;
          sb.push_back('{d: r_data, r: r_resp, l: (b == int'(len))});
          if (r_resp > exp_resp) exp_resp = r_resp;
          if (r_last != (b == int'(len))) exp_err = 1'b1;
          if (b == int'(len)) dq.push_back({exp_resp, exp_err});
        end
        @(posedge aclk);
        #1;
      end
      if (!got) check("r_ready_timeout", 0, 1);
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
    @(negedge aclk);
    check("done_timing", done, 1);
    check("rd_valid_with_done", rd_valid, 1);
    check("cmd_ready_in_done", cmd_ready, 1);
  endtask

  task automatic bad_cmd(input logic [2:0] size, input logic [1:0] burst);
    @(posedge aclk);
    #1;
    cmd_valid = 1'b1;
    cmd_size  = size;
    cmd_burst = burst;
    cmd_len   = 8'd3;
    dq.push_back({2'b10, 1'b0});
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
    @(negedge aclk);
    check("bad_done", done, 1);
    check("bad_no_ar", ar_valid, 0);
    check("bad_idle", cmd_ready, 1);
    @(negedge aclk);
    check("bad_no_ar_later", ar_valid, 0);
    check("bad_done_pulse", done, 0);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && (sb.size() != 0 || dq.size() != 0); t++) @(posedge aclk);
    check("sb_empty", sb.size(), 0);
    check("dq_empty", dq.size(), 0);
  endtask

  initial begin
    areset_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_size  = '0;
    cmd_burst = '0;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_data    = '0;
    r_last    = 1'b0;
    r_resp    = '0;
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_ar_valid", ar_valid, 0);
    check("rst_ar_addr", ar_addr, 0);
    check("rst_ar_len", ar_len, 0);
    check("rst_r_ready", r_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_done_resp", done_resp, 0);
    areset_n = 1'b1;

    run_burst(32'h100, 8'd0, 0, 32'hA5A5_A5A5, 32'h0, 16'h0001, -1);
    drain();
    run_burst(32'h2000, 8'd3, 5, 32'h1111_2222, 32'h0, 16'h0008, -1);
    drain();
    rd_toggle = 1'b1;
    run_burst(32'h3000, 8'd7, 1, 32'h3333_4444, 32'h0, 16'h0080, -1);
    drain();
    rd_toggle = 1'b0;
    run_burst(32'h4000, 8'd3, 0, 32'h5555_6666, 32'h0000_00C8, 16'h0008, -1);
    drain();
    run_burst(32'h5000, 8'd3, 2, 32'h7777_8888, 32'h0, 16'h000A, -1);
    drain();
    bad_cmd(3'd2, 2'b11);
    bad_cmd(3'd3, 2'b01);
    drain();

    run_burst(32'h6000, 8'd7, 0, 32'h9999_AAAA, 32'h0, 16'h0080, 2);
    drain();
    @(posedge aclk);
    #3;
    areset_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_ar_valid", ar_valid, 0);
    check("mid_rst_r_ready", r_ready, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ar_addr", ar_addr, 0);
    @(posedge aclk);
    #1;
    areset_n = 1'b1;
    run_burst(32'h7000, 8'd1, 0, 32'hBBBB_CCCC, 32'h4, 16'h0002, -1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
